hex_count_source: RTL and testbench
===================================

Name: hex_count_source

Overview:
- Two-digit counter that produces the 4-bit nibbles consumed by the board's pair of hex-digit decoders (Digit0 drives HEX0, Digit1 drives HEX1).
- A built-in rate divider advances the count at a selectable speed.
- Supports up/down counting, hex (00–FF) or BCD (00–99) range, and a parallel load from the switches.
- Sits directly upstream of the seven-segment decode stage. All outputs are registered.

Parameters:
- CLK_FREQ, 50000000, clock cycles per second; the rate-divider base period. Benches use 4.

Ports:
- Clock  input  1  system clock, rising edge
- Reset  input  1  synchronous, active-high reset
- Enable  input  1  1 = divider runs and count advances on ticks; 0 = freeze divider and count
- Speed  input  2  00 every cycle, 01 every CLK_FREQ cycles, 10 every 2*CLK_FREQ, 11 every 4*CLK_FREQ
- Up  input  1  1 = increment, 0 = decrement
- Bcd  input  1  1 = decimal range 00–99, 0 = hex range 00–FF
- Load  input  1  synchronous parallel load of LoadValue
- LoadValue  input  8  [3:0] low digit, [7:4] high digit
- Digit0  output  4  low-digit nibble to the HEX0 decoder
- Digit1  output  4  high-digit nibble to the HEX1 decoder
- Tick  output  1  one-cycle pulse; high in the first cycle a new advanced count is visible
- Wrap  output  1  one-cycle pulse, coincident with Tick, when the count wrapped

Behaviour:
- Reset (sampled on a Clock edge):
  - Digit0 = 0, Digit1 = 0, Tick = 0, Wrap = 0.
  - Divider loaded with period-1 for the current Speed.
  - Speed shadow register = Speed.
- Priority per edge: Reset > Load > speed change > tick.
- Period P: 1, CLK_FREQ, 2*CLK_FREQ or 4*CLK_FREQ, selected by Speed. Divider width is sized for 4*CLK_FREQ-1.
- Divider is a down-counter.
  - Internal advance = Enable & (div == 0).
  - On advance: div <= P-1.
  - Otherwise, if Enable: div <= div-1.
  - If Enable = 0: div holds, no advance, Tick = Wrap = 0.
- Speed = 00: advance on every enabled cycle; Tick stays high continuously while Enable = 1.
- Speed change: Speed is compared with its registered shadow. On mismatch, div <= new P-1, the shadow updates, and there is no advance that cycle.
- Load:
  - Digits <= LoadValue and div <= P-1; Tick = Wrap = 0 next cycle.
  - If Bcd = 1, any loaded nibble > 9 is stored as 9.
- Advance, hex mode: count treated as an 8-bit value.
  - Up: +1; FF -> 00 with Wrap = 1.
  - Down: -1; 00 -> FF with Wrap = 1.
- Advance, BCD mode, with both digits valid (<= 9):
  - Up: low digit 9 -> 0 with carry into the high digit; 99 -> 00 with Wrap = 1.
  - Down: low digit 0 -> 9 with borrow from the high digit; 00 -> 99 with Wrap = 1.
- Advance, BCD mode, with either digit > 9 (e.g. Bcd raised mid-run): count <= 00 and Wrap = 0.
- Tick and Wrap are registered. Both are 1 in exactly the cycle after the advancing edge, aligned with the updated digits; otherwise 0.
- Latency: Digit outputs change on the same edge at which advance is true; no additional pipeline.
- Up, Bcd and LoadValue are sampled only at the edge where they take effect; changes between ticks have no effect on the count until then.
- Reset asserted mid-period discards the divider progress. The first tick after reset release follows P cycles of Enable.

Test Plan:
- Reset, Enable = 1, Speed = 00, Up = 1, Bcd = 0 -> digits 00, 01, 02 … on successive cycles; at FF -> 00 Wrap = 1 for one cycle.
- CLK_FREQ = 4, Speed = 01, Enable = 1 from reset -> Tick every 4 cycles, digits 01, 02, 03; Enable = 0 for 3 cycles -> digits and divider frozen, no Tick; timing resumes where it stopped.
- Bcd = 1, Up = 1, Load 0x98 -> 99 then 00 with Wrap = 1; Up = 0 from 00 -> 99 with Wrap = 1; 10 -> 09 (borrow).
- Bcd = 1, Load 0xAF -> digits 9,9 stored; Bcd = 0, Load 0xAF, then raise Bcd and tick -> 00, Wrap = 0.
- Speed = 10 mid-period, change to 01 -> first Tick exactly 4 cycles after the change; Load and Reset asserted together -> reset wins (00).
- Load asserted on the same edge as a due advance -> LoadValue shown, Tick = 0, next Tick one full period later.

Source files
------------

// File: rtl/hex_count_source.sv
// Two-digit hex/BCD counter feeding the HEX1/HEX0 nibble decoders.
// A down-counting rate divider paces the advances; all outputs are registered.
module hex_count_source #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic [1:0] speed_i,
  input  logic       up_i,
  input  logic       bcd_i,
  input  logic       load_i,
  input  logic [7:0] load_value_i,
  output logic [3:0] digit0_o,
  output logic [3:0] digit1_o,
  output logic       tick_o,
  output logic       wrap_o
);

  localparam int DIV_W = (4 * CLK_FREQ > 1) ? $clog2(4 * CLK_FREQ) : 1;

  logic [3:0]       d0_q, d0_d;
  logic [3:0]       d1_q, d1_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       shadow_q, shadow_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  logic [DIV_W-1:0] period_m1;
  logic [3:0]       nxt0, nxt1;
  logic             nxt_wrap;
  logic [3:0]       ld0, ld1;
  logic             advance;

  always_comb begin
    case (speed_i)
      2'b00:   period_m1 = '0;
      2'b01:   period_m1 = DIV_W'(CLK_FREQ - 1);
      2'b10:   period_m1 = DIV_W'(2 * CLK_FREQ - 1);
      default: period_m1 = DIV_W'(4 * CLK_FREQ - 1);
    endcase
  end

  // In BCD mode the decoders cannot show A-F, so loaded nibbles saturate at 9.
  assign ld0 = (bcd_i && load_value_i[3:0] > 4'd9) ? 4'd9 : load_value_i[3:0];
  assign ld1 = (bcd_i && load_value_i[7:4] > 4'd9) ? 4'd9 : load_value_i[7:4];

  // Count value the digits take if this edge advances.
  always_comb begin
    nxt0     = d0_q;
    nxt1     = d1_q;
    nxt_wrap = 1'b0;
    if (!bcd_i) begin
      if (up_i) begin
        {nxt1, nxt0} = {d1_q, d0_q} + 8'd1;
        nxt_wrap     = ({d1_q, d0_q} == 8'hFF);
      end else begin
        {nxt1, nxt0} = {d1_q, d0_q} - 8'd1;
        nxt_wrap     = ({d1_q, d0_q} == 8'h00);
      end
    end else if (d1_q > 4'd9 || d0_q > 4'd9) begin
      nxt0 = 4'd0;
      nxt1 = 4'd0;
    end else if (up_i) begin
      if (d0_q == 4'd9) begin
        nxt0 = 4'd0;
        if (d1_q == 4'd9) begin
          nxt1     = 4'd0;
          nxt_wrap = 1'b1;
        end else begin
          nxt1 = d1_q + 4'd1;
        end
      end else begin
        nxt0 = d0_q + 4'd1;
      end
    end else begin
      if (d0_q == 4'd0) begin
        nxt0 = 4'd9;
        if (d1_q == 4'd0) begin
          nxt1     = 4'd9;
          nxt_wrap = 1'b1;
        end else begin
          nxt1 = d1_q - 4'd1;
        end
      end else begin
        nxt0 = d0_q - 4'd1;
      end
    end
  end

  assign advance = enable_i && (div_q == '0);

  // Load beats a speed change, which beats a due advance.
  always_comb begin
    d0_d     = d0_q;
    d1_d     = d1_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    tick_d   = 1'b0;
    wrap_d   = 1'b0;
    if (load_i) begin
      d0_d     = ld0;
      d1_d     = ld1;
      div_d    = period_m1;
      shadow_d = speed_i;
    end else if (speed_i != shadow_q) begin
      div_d    = period_m1;
      shadow_d = speed_i;
    end else if (advance) begin
      d0_d   = nxt0;
      d1_d   = nxt1;
      div_d  = period_m1;
      tick_d = 1'b1;
      wrap_d = nxt_wrap;
    end else if (enable_i) begin
      div_d = div_q - 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      d0_q     <= 4'd0;
      d1_q     <= 4'd0;
      div_q    <= period_m1;
      shadow_q <= speed_i;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      d0_q     <= d0_d;
      d1_q     <= d1_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      tick_q   <= tick_d;
      wrap_q   <= wrap_d;
    end
  end

  assign digit0_o = d0_q;
  assign digit1_o = d1_q;
  assign tick_o   = tick_q;
  assign wrap_o   = wrap_q;

endmodule

// File: tb/tb_hex_count_source.sv
// Bench for hex_count_source: expected {wrap, digit1, digit0} entries are queued
// by each scenario and consumed by a monitor on every Tick.
module tb_hex_count_source;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       enable_i = 1'b0;
  logic [1:0] speed_i = 2'b00;
  logic       up_i = 1'b1;
  logic       bcd_i = 1'b0;
  logic       load_i = 1'b0;
  logic [7:0] load_value_i = 8'h00;
  logic [3:0] digit0_o, digit1_o;
  logic       tick_o, wrap_o;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb_q[$];

  hex_count_source #(.CLK_FREQ(4)) dut (
    .clock_i(clk), .reset_i(reset_i), .enable_i(enable_i), .speed_i(speed_i),
    .up_i(up_i), .bcd_i(bcd_i), .load_i(load_i), .load_value_i(load_value_i),
    .digit0_o(digit0_o), .digit1_o(digit1_o), .tick_o(tick_o), .wrap_o(wrap_o)
  );

  always #5 clk = ~clk;

  // Every Tick must match the oldest queued expectation; Wrap never without Tick.
  always @(posedge clk) begin
    logic [8:0] exp_e;
    #1;
    if (tick_o === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_tick got=%b_%h%h exp=none", wrap_o, digit1_o, digit0_o);
      end else begin
        exp_e = sb_q.pop_front();
        if ({wrap_o, digit1_o, digit0_o} !== exp_e)
          begin errors++; $display("FAIL sb_tick got=%b_%h%h exp=%b_%h", wrap_o, digit1_o, digit0_o, exp_e[8], exp_e[7:0]); end
      end
    end else if (wrap_o === 1'b1) begin
      checks++; errors++;
      $display("FAIL wrap_without_tick got=1 exp=0");
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset(input logic [1:0] spd, input logic en);
    reset_i = 1'b1; speed_i = spd; enable_i = en; load_i = 1'b0;
    step(1);
    reset_i = 1'b0;
  endtask

  task automatic test_reset;
    enable_i = 1'b1; speed_i = 2'b00; up_i = 1'b1; bcd_i = 1'b0; reset_i = 1'b1;
    step(2);
    checks++; if ({digit1_o, digit0_o} !== 8'h00) begin errors++; $display("FAIL reset_digits got=%h%h exp=00", digit1_o, digit0_o); end
    checks++; if ({tick_o, wrap_o} !== 2'b00) begin errors++; $display("FAIL reset_tick_wrap got=%b%b exp=00", tick_o, wrap_o); end
    for (int i = 1; i <= 257; i++) sb_q.push_back({(i == 256), 8'(i % 256)});
    reset_i = 1'b0;
    step(257);
    enable_i = 1'b0;
    checks++; if ({digit1_o, digit0_o} !== 8'h01) begin errors++; $display("FAIL hex_run_end got=%h%h exp=01", digit1_o, digit0_o); end
    step(1);
    checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL hex_stop_tick got=%b exp=0", tick_o); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL hex_sb_left got=%0d exp=0", sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_rate;
    up_i = 1'b1; bcd_i = 1'b0;
    for (int i = 1; i <= 4; i++) sb_q.push_back({1'b0, 8'(i)});
    apply_reset(2'b01, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      step(1);
      checks++; if (tick_o !== (k % 4 == 0)) begin errors++; $display("FAIL rate_tick_c%0d got=%b exp=%b", k, tick_o, (k % 4 == 0)); end
    end
    enable_i = 1'b0;
    for (int k = 14; k <= 16; k++) begin
      step(1);
      checks++; if ({tick_o, digit1_o, digit0_o} !== 9'h003) begin errors++; $display("FAIL freeze_c%0d got=%b_%h%h exp=0_03", k, tick_o, digit1_o, digit0_o); end
    end
    enable_i = 1'b1;
    for (int k = 17; k <= 19; k++) begin
      step(1);
      checks++; if (tick_o !== (k == 19)) begin errors++; $display("FAIL resume_tick_c%0d got=%b exp=%b", k, tick_o, (k == 19)); end
    end
    enable_i = 1'b0;
    checks++; if ({digit1_o, digit0_o} !== 8'h04) begin errors++; $display("FAIL resume_digits got=%h%h exp=04", digit1_o, digit0_o); end
    step(1);
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL rate_sb_left got=%0d exp=0", sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_bcd;
    speed_i = 2'b00; bcd_i = 1'b1; up_i = 1'b1; enable_i = 1'b0;
    load_i = 1'b1; load_value_i = 8'h98;
    step(1);
    load_i = 1'b0;
    checks++; if ({tick_o, digit1_o, digit0_o} !== 9'h098) begin errors++; $display("FAIL bcd_load98 got=%b_%h%h exp=0_98", tick_o, digit1_o, digit0_o); end
    sb_q.push_back({1'b0, 8'h99}); sb_q.push_back({1'b1, 8'h00}); sb_q.push_back({1'b1, 8'h99});
    enable_i = 1'b1;
    step(2);
    up_i = 1'b0;
    step(1);
    enable_i = 1'b0;
    checks++; if ({wrap_o, digit1_o, digit0_o} !== 9'h199) begin errors++; $display("FAIL bcd_down_wrap got=%b_%h%h exp=1_99", wrap_o, digit1_o, digit0_o); end
    load_i = 1'b1; load_value_i = 8'h10;
    step(1);
    load_i = 1'b0;
    sb_q.push_back({1'b0, 8'h09});
    enable_i = 1'b1;
    step(1);
    enable_i = 1'b0;
    checks++; if ({digit1_o, digit0_o} !== 8'h09) begin errors++; $display("FAIL bcd_borrow got=%h%h exp=09", digit1_o, digit0_o); end
    step(1);
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL bcd_sb_left got=%0d exp=0", sb_q.size()); end
    sb_q.delete();
    up_i = 1'b1;
  endtask

  task automatic test_bcd_clamp;
    bcd_i = 1'b1; load_i = 1'b1; load_value_i = 8'hAF;
    step(1);
    checks++; if ({digit1_o, digit0_o} !== 8'h99) begin errors++; $display("FAIL clamp_load got=%h%h exp=99", digit1_o, digit0_o); end
    bcd_i = 1'b0;
    step(1);
    load_i = 1'b0;
    checks++; if ({digit1_o, digit0_o} !== 8'hAF) begin errors++; $display("FAIL hex_load_af got=%h%h exp=AF", digit1_o, digit0_o); end
    bcd_i = 1'b1;
    sb_q.push_back({1'b0, 8'h00});
    enable_i = 1'b1;
    step(1);
    enable_i = 1'b0;
    checks++; if ({wrap_o, digit1_o, digit0_o} !== 9'h000) begin errors++; $display("FAIL invalid_bcd got=%b_%h%h exp=0_00", wrap_o, digit1_o, digit0_o); end
    bcd_i = 1'b0;
    step(1);
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL clamp_sb_left got=%0d exp=0", sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_speed_change;
    up_i = 1'b1; bcd_i = 1'b0;
    sb_q.push_back({1'b0, 8'h01});
    apply_reset(2'b10, 1'b1);
    step(3);
    speed_i = 2'b01;
    step(1);
    checks++; if (tick_o !== 1'b0) begin errors++; $display("FAIL spdchg_edge_tick got=%b exp=0", tick_o); end
    for (int k = 1; k <= 4; k++) begin
      step(1);
      checks++; if (tick_o !== (k == 4)) begin errors++; $display("FAIL spdchg_tick_c%0d got=%b exp=%b", k, tick_o, (k == 4)); end
    end
    checks++; if ({digit1_o, digit0_o} !== 8'h01) begin errors++; $display("FAIL spdchg_digits got=%h%h exp=01", digit1_o, digit0_o); end
    reset_i = 1'b1; load_i = 1'b1; load_value_i = 8'h55;
    step(1);
    reset_i = 1'b0; load_i = 1'b0; enable_i = 1'b0;
    checks++; if ({digit1_o, digit0_o} !== 8'h00) begin errors++; $display("FAIL reset_over_load got=%h%h exp=00", digit1_o, digit0_o); end
    step(1);
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL spdchg_sb_left got=%0d exp=0", sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_load_on_advance;
    up_i = 1'b1; bcd_i = 1'b0;
    sb_q.push_back({1'b0, 8'h43});
    apply_reset(2'b01, 1'b1);
    step(3);
    load_i = 1'b1; load_value_i = 8'h42;
    step(1);
    load_i = 1'b0;
    checks++; if ({tick_o, digit1_o, digit0_o} !== 9'h042) begin errors++; $display("FAIL load_vs_adv got=%b_%h%h exp=0_42", tick_o, digit1_o, digit0_o); end
    for (int k = 1; k <= 4; k++) begin
      step(1);
      checks++; if (tick_o !== (k == 4)) begin errors++; $display("FAIL post_load_tick_c%0d got=%b exp=%b", k, tick_o, (k == 4)); end
    end
    checks++; if ({digit1_o, digit0_o} !== 8'h43) begin errors++; $display("FAIL post_load_digits got=%h%h exp=43", digit1_o, digit0_o); end
    enable_i = 1'b0;
    step(1);
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL load_sb_left got=%0d exp=0", sb_q.size()); end
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_rate();
    test_bcd();
    test_bcd_clamp();
    test_speed_change();
    test_load_on_advance();
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
